// File: rtl/vu_level_tracker.sv
// ---------------------------------------------------------------------------
// vu_level_tracker
//
// Peak-hold VU meter core fed by a UART byte stream of offset-binary audio
// samples. Each qualifying byte is converted to a 0..127 magnitude. If that
// magnitude is at least the current level, it becomes the new level. The
// level is held for HOLD_CYCLES clocks and then decays by one LSB every
// DECAY_CYCLES clocks until it reaches zero.
//
// Parameters
//   HOLD_CYCLES   clocks the peak is held after the last qualifying load (>=1)
//   DECAY_CYCLES  clocks per 1-LSB decrement while decaying (>=1)
//
// Ports
//   clk         system clock, all state changes on the rising edge
//   rst         asynchronous, active-high reset
//   valid       one-cycle strobe: data_in / format_err are meaningful
//   format_err  framing error qualifier for the byte strobed by valid
//   data_in     received sample, offset binary (128 = silence)
//   level       tracked peak magnitude, 0..127 (registered)
//   bar         thermometer LED drive, bar[i] = (level > 16*i)
//   clip        high while the held peak came from a full-scale sample
//   err_cnt     saturating count of bytes rejected for framing errors
// ---------------------------------------------------------------------------
module vu_level_tracker #(
   parameter int HOLD_CYCLES  = 1000,
   parameter int DECAY_CYCLES = 500
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       valid,
   input  logic       format_err,
   input  logic [7:0] data_in,
   output logic [6:0] level,
   output logic [7:0] bar,
   output logic       clip,
   output logic [7:0] err_cnt
);

   // Both counters share one width, large enough for the longer interval.
   localparam int MAX_CYCLES = (HOLD_CYCLES > DECAY_CYCLES) ? HOLD_CYCLES : DECAY_CYCLES;
   localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

   localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] DECAY_LOAD = CNT_W'(DECAY_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_HOLD  = 2'd1,
      ST_DECAY = 2'd2
   } state_t;

   state_t           state_reg;
   logic [6:0]       level_reg;
   logic             clip_reg;
   logic [7:0]       err_cnt_reg;
   logic [CNT_W-1:0] hold_cnt_reg;
   logic [CNT_W-1:0] decay_cnt_reg;

   logic [6:0]       mag;
   logic             sample_ok;
   logic             sample_err;
   logic             sample_load;

   // -----------------------------------------------------------------------
   // Sample magnitude.
   // Upper half: data_in - 128 is simply the low seven bits.
   // Lower half: 128 - data_in is the two's-complement negation of the low
   // seven bits. The only value that needs clamping is data_in = 0,
   // because 128 does not fit in seven bits.
   // -----------------------------------------------------------------------
   always_comb begin
      mag = 7'd0;
      if (data_in[7]) begin
         mag = data_in[6:0];
      end else if (data_in == 8'd0) begin
         mag = 7'd127;
      end else begin
         mag = 7'd0 - data_in[6:0];
      end
   end

   assign sample_ok  = valid && !format_err;
   assign sample_err = valid && format_err;

   // A load needs mag >= level. A zero magnitude never starts a hold: if
   // level is also zero, the meter stays idle. The comparison uses the
   // pre-decrement level, so a sample that ties the current level beats a
   // decay step on the same edge.
   assign sample_load = sample_ok && (mag != 7'd0) && (mag >= level_reg);

   // -----------------------------------------------------------------------
   // Tracker state machine plus registered outputs
   // -----------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= ST_IDLE;
         level_reg     <= 7'd0;
         clip_reg      <= 1'b0;
         err_cnt_reg   <= 8'd0;
         hold_cnt_reg  <= '0;
         decay_cnt_reg <= '0;
      end else begin
         // The framing-error counter is independent of the level path.
         if (sample_err && (err_cnt_reg != 8'hFF)) begin
            err_cnt_reg <= err_cnt_reg + 8'd1;
         end

         if (sample_load) begin
            level_reg     <= mag;
            clip_reg      <= (mag == 7'd127);
            hold_cnt_reg  <= HOLD_LOAD;
            decay_cnt_reg <= '0;
            state_reg     <= ST_HOLD;
         end else begin
            case (state_reg)
               ST_IDLE: begin
                  hold_cnt_reg  <= '0;
                  decay_cnt_reg <= '0;
               end

               // The counter is loaded with HOLD_CYCLES-1 and is seen at
               // zero on the HOLD_CYCLES-th edge after the load. That edge
               // hands over to decay.
               ST_HOLD: begin
                  if (hold_cnt_reg == '0) begin
                     decay_cnt_reg <= DECAY_LOAD;
                     state_reg     <= ST_DECAY;
                  end else begin
                     hold_cnt_reg <= hold_cnt_reg - CNT_ONE;
                  end
               end

               ST_DECAY: begin
                  if (decay_cnt_reg == '0) begin
                     // level is never zero in this state, so it cannot
                     // underflow. Any decrement takes it below full scale.
                     level_reg     <= level_reg - 7'd1;
                     clip_reg      <= 1'b0;
                     decay_cnt_reg <= DECAY_LOAD;
                     if (level_reg == 7'd1) begin
                        decay_cnt_reg <= '0;
                        state_reg     <= ST_IDLE;
                     end
                  end else begin
                     decay_cnt_reg <= decay_cnt_reg - CNT_ONE;
                  end
               end

               default: begin
                  state_reg     <= ST_IDLE;
                  level_reg     <= 7'd0;
                  clip_reg      <= 1'b0;
                  hold_cnt_reg  <= '0;
                  decay_cnt_reg <= '0;
               end
            endcase
         end
      end
   end

   // -----------------------------------------------------------------------
   // Thermometer drive, decoded from the level register only
   // -----------------------------------------------------------------------
   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_bar
         assign bar[gi] = ({1'b0, level_reg} > 8'(16 * gi));
      end
   endgenerate

   assign level   = level_reg;
   assign clip    = clip_reg;
   assign err_cnt = err_cnt_reg;

endmodule

// File: tb/tb_vu_level_tracker.sv
// ---------------------------------------------------------------------------
// tb_vu_level_tracker
//
// Scoreboarded bench for vu_level_tracker with HOLD_CYCLES=8, DECAY_CYCLES=4.
// On every rising edge, a reference model predicts the outputs and pushes
// them into a queue. A monitor pops that queue on each falling edge and
// compares the prediction with the DUT outputs.
//
// The model keeps the loaded peak and the edge index of that load. It then
// computes the level after any edge in closed form: the number of decay
// steps is (elapsed - HOLD) / DECAY once the hold has expired.
// ---------------------------------------------------------------------------
module tb_vu_level_tracker;

   localparam int H = 8;
   localparam int D = 4;

   logic       clk;
   logic       rst;
   logic       valid;
   logic       format_err;
   logic [7:0] data_in;
   logic [6:0] level;
   logic [7:0] bar;
   logic       clip;
   logic [7:0] err_cnt;

   int total = 0;
   int bad   = 0;

   vu_level_tracker #(
      .HOLD_CYCLES (H),
      .DECAY_CYCLES(D)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .valid     (valid),
      .format_err(format_err),
      .data_in   (data_in),
      .level     (level),
      .bar       (bar),
      .clip      (clip),
      .err_cnt   (err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- comparison helper ----------------
   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      int lvl;
      int bar;
      int clip;
      int err;
   } exp_t;

   exp_t exp_q[$];

   int  cyc    = 0;   // index of the most recent rising edge
   int  t0     = 0;   // edge at which the current peak was loaded
   int  peak   = 0;
   bit  active = 0;
   int  errs   = 0;

   function automatic int ref_mag(input logic [7:0] d);
      int s;
      s = int'(d) - 128;
      if (s < 0) s = -s;
      if (s > 127) s = 127;
      return s;
   endfunction

   // Level right after edge c.
   function automatic int lvl_after(input int c);
      int k;
      int n;
      if (!active) return 0;
      k = c - t0;
      n = (k >= H) ? (k - H) / D : 0;
      return (n >= peak) ? 0 : peak - n;
   endfunction

   // The number of lit segments is ceil(level / 16).
   function automatic int ref_bar(input int l);
      int nb;
      nb = (l + 15) / 16;
      return ((1 << nb) - 1) & 255;
   endfunction

   always @(posedge clk) begin
      exp_t e;
      int   m;
      int   l;
      cyc++;
      if (rst) begin
         active = 0;
         errs   = 0;
      end else if (valid) begin
         if (format_err) begin
            if (errs < 255) errs++;
         end else begin
            m = ref_mag(data_in);
            if (m != 0 && m >= lvl_after(cyc - 1)) begin
               active = 1;
               peak   = m;
               t0     = cyc;
            end
         end
      end
      l      = lvl_after(cyc);
      e.lvl  = l;
      e.bar  = ref_bar(l);
      e.clip = (active && peak == 127 && l == 127) ? 1 : 0;
      e.err  = errs;
      exp_q.push_back(e);
   end

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() == 0) begin
         chk("sb_empty", 0, 1);
      end else begin
         e = exp_q.pop_front();
         chk("sb_level", int'(level), e.lvl);
         chk("sb_bar", int'(bar), e.bar);
         chk("sb_clip", int'(clip), e.clip);
         chk("sb_err_cnt", int'(err_cnt), e.err);
      end
   end

   // ---------------- stimulus ----------------
   // Called just after a falling edge. Drives one strobe for one cycle and
   // returns just after the next falling edge.
   task automatic send(input logic fe, input logic [7:0] d);
      valid      = 1'b1;
      format_err = fe;
      data_in    = d;
      @(negedge clk);
      valid      = 1'b0;
      format_err = 1'b0;
      data_in    = 8'h80;
   endtask

   initial begin
      rst        = 1'b1;
      valid      = 1'b0;
      format_err = 1'b0;
      data_in    = 8'h80;
      repeat (3) @(negedge clk);
      chk("reset_level", int'(level), 0);
      chk("reset_bar", int'(bar), 0);
      chk("reset_clip", int'(clip), 0);
      chk("reset_err", int'(err_cnt), 0);
      rst = 1'b0;
      @(negedge clk);

      // Mid-scale peak: hold, then the first decay step.
      send(1'b0, 8'hC0);
      chk("c0_level", int'(level), 64);
      chk("c0_bar", int'(bar), 8'h0F);
      chk("c0_clip", int'(clip), 0);
      repeat (11) @(negedge clk);
      chk("c0_last_held", int'(level), 64);
      @(negedge clk);
      chk("c0_first_decay", int'(level), 63);

      // Full-scale peak: clip is set, then cleared on the first decrement.
      send(1'b0, 8'h00);
      chk("fs_level", int'(level), 127);
      chk("fs_bar", int'(bar), 8'hFF);
      chk("fs_clip", int'(clip), 1);
      repeat (11) @(negedge clk);
      chk("fs_clip_held", int'(clip), 1);
      @(negedge clk);
      chk("fs_decay_level", int'(level), 126);
      chk("fs_decay_clip", int'(clip), 0);
      repeat (510) @(negedge clk);
      chk("fs_decayed_out", int'(level), 0);

      // Smaller sample is ignored; an equal sample restarts the hold.
      send(1'b0, 8'hC0);
      repeat (3) @(negedge clk);
      send(1'b0, 8'hA0);
      chk("small_ignored", int'(level), 64);
      repeat (2) @(negedge clk);
      send(1'b0, 8'h40);
      repeat (11) @(negedge clk);
      chk("hold_extended", int'(level), 64);
      @(negedge clk);
      chk("hold_ext_decay", int'(level), 63);

      // Framing errors are counted and saturate at 255.
      send(1'b1, 8'hFF);
      chk("err_first", int'(err_cnt), 1);
      for (int i = 0; i < 299; i++) send(1'b1, 8'hFF);
      chk("err_saturated", int'(err_cnt), 255);

      // Decay from level 2 to 0, then stay idle.
      repeat (300) @(negedge clk);
      chk("pre_small_level", int'(level), 0);
      send(1'b0, 8'h80);
      chk("mag0_idle", int'(level), 0);
      send(1'b0, 8'h82);
      chk("lvl2_load", int'(level), 2);
      repeat (12) @(negedge clk);
      chk("lvl2_to_1", int'(level), 1);
      repeat (4) @(negedge clk);
      chk("lvl1_to_0", int'(level), 0);
      chk("lvl0_bar", int'(bar), 0);
      repeat (20) @(negedge clk);
      chk("lvl0_stays", int'(level), 0);
      send(1'b0, 8'h7F);
      chk("mag1_load", int'(level), 1);

      // Reset in the middle of decay.
      #2 rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 7; i++) send(1'b1, 8'h12);
      chk("err_seven", int'(err_cnt), 7);
      send(1'b0, 8'hB2);
      chk("b2_level", int'(level), 50);
      repeat (10) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("async_level", int'(level), 0);
      chk("async_bar", int'(bar), 0);
      chk("async_clip", int'(clip), 0);
      chk("async_err", int'(err_cnt), 0);
      valid   = 1'b1;
      data_in = 8'h00;
      @(negedge clk);
      valid   = 1'b0;
      data_in = 8'h80;
      rst     = 1'b0;
      repeat (30) @(negedge clk);
      chk("post_rst_level", int'(level), 0);
      send(1'b0, 8'h90);
      chk("bar_16", int'(bar), 8'h01);
      send(1'b0, 8'h91);
      chk("bar_17", int'(bar), 8'h03);

      // Randomized traffic: alternating dense and sparse phases, so that
      // both hold restarts and long decays occur, with occasional resets.
      for (int i = 0; i < 4000; i++) begin
         bit sparse;
         sparse     = ((i / 500) % 2) == 1;
         valid      = sparse ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 3) == 0);
         format_err = ($urandom_range(0, 7) == 0);
         data_in    = 8'($urandom);
         if ($urandom_range(0, 699) == 0) begin
            #2 rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
         end else begin
            @(negedge clk);
         end
      end
      valid      = 1'b0;
      format_err = 1'b0;
      repeat (3) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/vu_level_tracker.md
VU_LEVEL_TRACKER -- requirements
Module: vu_level_tracker

Interface
REQ-001 Parameter HOLD_CYCLES, default 1000, clock cycles the peak is held after the last qualifying sample (>=1).
REQ-002 Parameter DECAY_CYCLES, default 500, clock cycles per 1-LSB level decrement during decay (>=1).
REQ-003 clk  input  1  single system clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 valid  input  1  one-cycle strobe from the UART receiver: data_in/format_err meaningful this cycle.
REQ-006 format_err  input  1  UART framing error qualifier, sampled only when valid=1.
REQ-007 data_in  input  8  received audio sample, offset binary (128 = silence).
REQ-008 level  output  7  current tracked peak magnitude, 0..127.
REQ-009 bar  output  8  thermometer LED drive derived from level.
REQ-010 clip  output  1  high while the held peak came from a full-scale sample.
REQ-011 err_cnt  output  8  saturating count of rejected (format_err) bytes.

Function
REQ-012 Magnitude SHALL be mag = data_in-128 when data_in[7]=1, else 128-data_in, clamped to 127 (data_in=0 -> 127).
REQ-013 Qualifying sample: valid=1 and format_err=0; only qualifying samples affect level/clip/state.
REQ-014 valid=1 with format_err=1: sample discarded; err_cnt increments by 1, saturates at 255, never wraps.
REQ-015 valid=0: format_err and data_in ignored.
REQ-016 State machine states IDLE (level=0, no activity), HOLD, DECAY; encoding free.
REQ-017 Qualifying sample with mag >= level (any state): level <= mag, hold counter <= HOLD_CYCLES-1, state -> HOLD; visible on level one cycle after valid.
REQ-018 Qualifying sample with mag < level: no effect on level, counters, state.
REQ-019 Qualifying sample with mag=0 and level=0: state stays/goes IDLE, no hold started.
REQ-020 HOLD: hold counter decrements each cycle; on reaching 0 (exactly HOLD_CYCLES cycles after load) -> DECAY, decay counter <= DECAY_CYCLES-1.
REQ-021 DECAY: decay counter decrements each cycle; on reaching 0, level <= level-1 and decay counter reloads; first decrement exactly DECAY_CYCLES cycles after DECAY entry.
REQ-022 DECAY: when decrement makes level 0 -> IDLE; level never underflows.
REQ-023 Simultaneous decay step and qualifying sample with mag >= level-1: sample wins (REQ-017 applies using pre-decrement comparison mag >= level; if mag < level, decrement proceeds).
REQ-024 bar[i] SHALL be 1 iff level > 16*i, i=0..7; combinational from level register (level=0 -> 8'h00, level=127 -> 8'hFF, level=16 -> 8'h01, level=17 -> 8'h03).
REQ-025 clip set when a qualifying sample with mag=127 is loaded; cleared when level first drops below 127 or on load of a sample with mag<127.
REQ-026 All counters sized to hold max(HOLD_CYCLES,DECAY_CYCLES)-1; no combinational path from inputs to outputs.

Reset
REQ-027 rst=1 SHALL immediately force: level=0, bar=8'h00, clip=0, err_cnt=0, state IDLE, hold/decay counters 0.
REQ-028 Reset asserted mid-HOLD or mid-DECAY aborts operation; valid during rst=1 ignored; first qualifying sample after deassertion processed normally.

Verification (bench uses HOLD_CYCLES=8, DECAY_CYCLES=4)
REQ-029 Reset then data_in=8'hC0 valid -> next cycle level=64, bar=8'h0F, clip=0; level held 8 cycles, then decrements to 63 four cycles later.
REQ-030 data_in=8'h00 valid -> level=127, bar=8'hFF, clip=1; after hold plus 4 cycles level=126, clip=0.
REQ-031 Level=64 in HOLD, sample 8'hA0 (mag 32) -> no change; sample 8'h40 (mag 64) -> hold counter restarts, HOLD extends 8 cycles.
REQ-032 Valid with format_err=1, data_in=8'hFF -> level unchanged, err_cnt+1; 300 such strobes -> err_cnt=255.
REQ-033 Level=2 decaying, no samples -> level 1 then 0 at 4-cycle spacing, state IDLE, bar=8'h00, stays 0.
REQ-034 rst pulsed during DECAY with level=50, err_cnt=7 -> all outputs 0 within same cycle, no decay after release.
